// File: rtl/move_set_fifo.sv
// Elastic DEPTH-entry FIFO for move-set bundles (NRAY ray fields + NKN knight fields).
// Valid/ready on both sides, registered head data, occupancy report and synchronous flush.
module move_set_fifo #(
    parameter int NRAY  = 8,
    parameter int RAY_W = 11,
    parameter int NKN   = 8,
    parameter int KN_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET_N,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [NRAY*RAY_W-1:0]        RAY_IN,
    input  logic [NKN*KN_W-1:0]          KN_IN,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [NRAY*RAY_W-1:0]        RAY_OUT,
    output logic [NKN*KN_W-1:0]          KN_OUT,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL
);

    localparam int RW = NRAY * RAY_W;
    localparam int KW = NKN * KN_W;
    localparam int BW = RW + KW;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] head_q, head_d;
    logic [BW-1:0] in_bundle_s;
    logic          push_s;
    logic          pop_s;

    assign in_bundle_s = {RAY_IN, KN_IN};
    assign push_s      = IN_VALID & in_ready_q;
    assign pop_s       = out_valid_q & OUT_READY;

    // Next-state: storage, pointers, occupancy and registered head/flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = in_bundle_s;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // The head register mirrors mem_q[rd_ptr]; refresh it whenever the head slot changes.
            if (pop_s) begin
                if (level_q == LW'(1)) begin
                    if (push_s) begin
                        head_d = in_bundle_s;
                    end else begin
                        head_d = head_q;
                    end
                end else begin
                    head_d = mem_q[rd_ptr_q + PW'(1)];
                end
            end else if (push_s && (level_q == LW'(0))) begin
                head_d = in_bundle_s;
            end else begin
                head_d = head_q;
            end
        end
        in_ready_d  = (level_d < LW'(DEPTH));
        out_valid_d = (level_d != LW'(0));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign LEVEL     = level_q;
    assign RAY_OUT   = head_q[BW-1:KW];
    assign KN_OUT    = head_q[KW-1:0];

endmodule
